// File: rtl/action_pkg.sv
// Shared definitions for the action driver: command bit positions,
// FSM state encodings and a command validity helper.
package action_pkg;

  // Bit positions inside control_data / btn_out.
  localparam int CD_MOVE     = 4;
  localparam int CD_THROW    = 3;
  localparam int CD_INTERACT = 2;
  localparam int CD_PUT      = 1;
  localparam int CD_GET      = 0;

  localparam logic [4:0] CMD_NONE = 5'b00000;
  localparam logic [4:0] CMD_MOVE = 5'b10000;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  // True when the command is zero or carries exactly one set bit.
  function automatic logic onehot_ok(input logic [4:0] cmd);
    return (cmd & (cmd - 5'd1)) == 5'd0;
  endfunction

endpackage

// File: rtl/action_driver_hold_timer.sv
// Loadable down-counter shared by the HOLD and GAP phases. After a load of
// N, expire is high on the N-th cycle following the load; the count then
// sits at zero and never wraps.
module hold_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expire
);

  logic [WIDTH-1:0] cnt;

  // Load takes priority; otherwise count down and saturate at zero.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples the pre-edge value of its neighbours.
    if (rst)               cnt <= '0;
    else if (load)         cnt <= value;
    else if (cnt != '0)    cnt <= cnt - WIDTH'(1);
  end

  assign expire = (cnt == WIDTH'(1));

endmodule

// File: rtl/action_driver.sv
// Executes one-hot commands from the action stage: MOVE holds the move
// button until position feedback settles on the target, the other actions
// produce a single timed press followed by a release gap and a done pulse.
import action_pkg::*;

module action_driver #(
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 2000000,
  parameter int SETTLE      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] control_data,
  input  logic [7:0] target_machine,
  input  logic       feedback_valid,
  input  logic [7:0] feedback_machine,
  output logic       move_ready,
  output logic [4:0] btn_out,
  output logic [7:0] move_target,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int MW   = $clog2(SETTLE + 1);

  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] GAP_LOAD    = TW'(GAP_CYCLES);
  localparam logic [MW-1:0] SETTLE_LAST = MW'(SETTLE - 1);

  logic [1:0]    state;
  logic [4:0]    cmd;
  logic [4:0]    last_cmd;
  logic [MW-1:0] match_cnt;

  logic          is_move;
  logic          cd_ok;
  logic          accept_move;
  logic          accept_action;
  logic          fb_hit;
  logic          timer_load;
  logic [TW-1:0] timer_value;
  logic          expire;

  // Decode of the incoming command against the current context.
  always_comb begin
    is_move       = (control_data == CMD_MOVE);
    cd_ok         = onehot_ok(control_data);
    // A move that has already arrived at the same target is not restarted
    // while the command level is still held.
    accept_move   = en && is_move &&
                    !(move_ready && (target_machine == move_target));
    // Actions are edge-like: a held level is pressed only once.
    accept_action = en && cd_ok && (control_data != CMD_NONE) &&
                    !control_data[CD_MOVE] && (control_data != last_cmd);
    fb_hit        = feedback_valid && (feedback_machine == move_target);
    // NOTE: every signal driven here gets a value on every path, so no
    // latch is inferred.
    timer_load    = ((state == ST_IDLE) && accept_action && !accept_move) ||
                    ((state == ST_HOLD) && expire);
    timer_value   = (state == ST_IDLE) ? HOLD_LOAD : GAP_LOAD;
  end

  hold_timer #(.WIDTH(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .value  (timer_value),
    .expire (expire)
  );

  // Main sequencer: state, button drive, arrival tracking and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cmd         <= CMD_NONE;
      last_cmd    <= CMD_NONE;
      match_cnt   <= '0;
      move_ready  <= 1'b0;
      btn_out     <= CMD_NONE;
      move_target <= 8'h00;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      // Arrival is only meaningful while enabled and aimed at the same target.
      if (!en || (target_machine != move_target)) move_ready <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!en || (control_data == CMD_NONE)) begin
            last_cmd <= CMD_NONE;
          end else if (!cd_ok) begin
            err <= 1'b1;
          end else if (accept_move) begin
            move_target <= target_machine;
            match_cnt   <= '0;
            btn_out     <= CMD_MOVE;
            state       <= ST_MOVE;
          end else if (accept_action) begin
            cmd     <= control_data;
            btn_out <= control_data;
            state   <= ST_HOLD;
          end
        end

        ST_MOVE: begin
          if (!en || !is_move) begin
            btn_out    <= CMD_NONE;
            match_cnt  <= '0;
            move_ready <= 1'b0;
            state      <= ST_IDLE;
          end else if (target_machine != move_target) begin
            move_target <= target_machine;
            match_cnt   <= '0;
          end else if (feedback_valid) begin
            if (fb_hit) begin
              if (match_cnt == SETTLE_LAST) begin
                move_ready <= 1'b1;
                btn_out    <= CMD_NONE;
                match_cnt  <= '0;
                state      <= ST_IDLE;
              end else begin
                match_cnt <= match_cnt + MW'(1);
              end
            end else begin
              match_cnt <= '0;
            end
          end
        end

        ST_HOLD: begin
          if (expire) begin
            btn_out <= CMD_NONE;
            state   <= ST_GAP;
          end
        end

        default: begin // ST_GAP
          if (expire) begin
            last_cmd   <= cmd;
            move_ready <= 1'b0;
            state      <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_GAP) && expire;

endmodule

// File: tb/tb_action_driver.sv
// Directed self-checking bench for action_driver with HOLD=4, GAP=3,
// SETTLE=2. Inputs change 1 time unit after a rising edge and outputs are
// sampled at that same point, i.e. just after the edge that produced them.
module tb_action_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [4:0] control_data;
  logic [7:0] target_machine;
  logic       feedback_valid;
  logic [7:0] feedback_machine;
  logic       move_ready;
  logic [4:0] btn_out;
  logic [7:0] move_target;
  logic       busy;
  logic       done;
  logic       err;

  int total_cnt = 0;
  int pass_cnt  = 0;

  action_driver #(.HOLD_CYCLES(4), .GAP_CYCLES(3), .SETTLE(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .control_data     (control_data),
    .target_machine   (target_machine),
    .feedback_valid   (feedback_valid),
    .feedback_machine (feedback_machine),
    .move_ready       (move_ready),
    .btn_out          (btn_out),
    .move_target      (move_target),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; control_data = 5'b0; target_machine = 8'h00;
    feedback_valid = 1'b0; feedback_machine = 8'h00;
    step(); step();
    check("rst_btn", {3'b0, btn_out}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    check("rst_ready", {7'b0, move_ready}, 8'h00);
    check("rst_done_err", {6'b0, done, err}, 8'h00);
    check("rst_target", move_target, 8'h00);
    rst = 1'b0;
    step();

    // Single GET press held as a level: 4 cycles high, 3 released, done once.
    en = 1'b1; control_data = 5'b00001;
    for (int i = 0; i < 4; i++) begin
      step();
      check("get_hold_btn", {3'b0, btn_out}, 8'h01);
      check("get_hold_busy", {6'b0, busy, done}, 8'h02);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      check("get_gap_btn", {3'b0, btn_out}, 8'h00);
      check("get_gap_done", {7'b0, done}, (i == 3) ? 8'h01 : 8'h00);
    end
    step();
    check("get_end_idle", {6'b0, busy, done}, 8'h00);
    step(); step();
    check("get_no_repress", {2'b0, busy, btn_out}, 8'h00);
    control_data = 5'b00000;
    step();
    control_data = 5'b00001;
    step();
    check("get_repress", {3'b0, btn_out}, 8'h01);
    control_data = 5'b00000;
    repeat (7) step();
    check("get_repress_end", {3'b0, btn_out}, 8'h00);
    check("get_repress_idle", {7'b0, busy}, 8'h00);

    // MOVE to 0x05 with two matching samples.
    control_data = 5'b10000; target_machine = 8'h05;
    step();
    check("mv1_btn", {3'b0, btn_out}, 8'h10);
    check("mv1_target", move_target, 8'h05);
    feedback_valid = 1'b1; feedback_machine = 8'h05;
    step();
    check("mv1_first_sample", {7'b0, move_ready}, 8'h00);
    step();
    check("mv1_ready", {7'b0, move_ready}, 8'h01);
    check("mv1_btn_drop", {2'b0, busy, btn_out}, 8'h00);
    feedback_valid = 1'b0;
    step();
    check("mv1_held_no_restart", {2'b0, busy, btn_out}, 8'h00);
    check("mv1_held_ready", {7'b0, move_ready}, 8'h01);
    en = 1'b0; control_data = 5'b00000;
    step();
    check("mv1_en_clears_ready", {7'b0, move_ready}, 8'h00);

    // MOVE to 0x05 with an interrupted match sequence.
    en = 1'b1; control_data = 5'b10000;
    step();
    feedback_valid = 1'b1;
    feedback_machine = 8'h05; step();
    feedback_machine = 8'h03; step();
    check("mv2_miss_ready", {7'b0, move_ready}, 8'h00);
    check("mv2_miss_btn", {3'b0, btn_out}, 8'h10);
    feedback_machine = 8'h05; step();
    check("mv2_rematch1", {7'b0, move_ready}, 8'h00);
    step();
    check("mv2_ready", {7'b0, move_ready}, 8'h01);
    check("mv2_btn_drop", {3'b0, btn_out}, 8'h00);
    feedback_valid = 1'b0;
    control_data = 5'b00000; target_machine = 8'h07;
    step();
    check("mv2_target_change_clears", {7'b0, move_ready}, 8'h00);

    // MOVE re-latch on target change, then abort by en=0.
    control_data = 5'b10000;
    step();
    check("mv3_target", move_target, 8'h07);
    target_machine = 8'h09;
    step();
    check("mv3_relatch", move_target, 8'h09);
    check("mv3_still_busy", {2'b0, busy, btn_out}, 8'h30);
    en = 1'b0;
    step();
    check("mv3_abort_btn", {2'b0, busy, btn_out}, 8'h00);
    check("mv3_abort_flags", {6'b0, move_ready, done}, 8'h00);

    // Multi-hot command in IDLE.
    en = 1'b1; control_data = 5'b00011;
    step();
    check("err_pulse", {7'b0, err}, 8'h01);
    check("err_btn", {2'b0, busy, btn_out}, 8'h00);
    control_data = 5'b00000;
    step();
    check("err_clear", {7'b0, err}, 8'h00);

    // INTERACT press: en drop ignored mid-HOLD, then reset aborts.
    control_data = 5'b00100;
    step();
    check("int_btn", {3'b0, btn_out}, 8'h04);
    en = 1'b0; control_data = 5'b00000;
    step();
    check("int_atomic", {2'b0, busy, btn_out}, 8'h24);
    rst = 1'b1;
    step();
    check("int_rst_btn", {2'b0, busy, btn_out}, 8'h00);
    check("int_rst_flags", {5'b0, move_ready, done, err}, 8'h00);
    rst = 1'b0;
    step();
    check("int_rst_idle", {7'b0, busy}, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
